// File: rtl/switch_debouncer_pkg.sv
// switch_debouncer_pkg: per-channel state encoding, counter-width helper and default 10 ms at 100 MHz debounce time
package switch_debouncer_pkg;
  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    WAIT_HIGH   = 2'd1,
    HIGH_STABLE = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one switch (clock, i_reset async high, i_switch raw) -> synchronised, debounced o_level with one-cycle o_rise/o_fall
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_switch,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  state_t state;
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      state   <= LOW_STABLE;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      s1     <= i_switch;
      s2     <= s1;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      case (state)
        LOW_STABLE: begin
          state <= s2 ? WAIT_HIGH : LOW_STABLE;
          cnt   <= s2 ? CNT_ONE : '0;
        end
        WAIT_HIGH:
          if (!s2) begin
            state <= LOW_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state   <= HIGH_STABLE;
            o_level <= 1'b1;
            o_rise  <= 1'b1;
            cnt     <= '0;
          end else cnt <= cnt + CNT_ONE;
        HIGH_STABLE: begin
          state <= s2 ? HIGH_STABLE : WAIT_LOW;
          cnt   <= s2 ? '0 : CNT_ONE;
        end
        WAIT_LOW:
          if (s2) begin
            state <= HIGH_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state   <= LOW_STABLE;
            o_level <= 1'b0;
            o_fall  <= 1'b1;
            cnt     <= '0;
          end else cnt <= cnt + CNT_ONE;
      endcase
    end
  end
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: NB_CH independent debounce channels (clock, i_reset, i_switch -> o_level, o_rise, o_fall)
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int NB_CH           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_CH-1:0] i_switch,
  output logic [NB_CH-1:0] o_level,
  output logic [NB_CH-1:0] o_rise,
  output logic [NB_CH-1:0] o_fall
);
  for (genvar i = 0; i < NB_CH; i++) begin : g_ch
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clock   (clock),
      .i_reset (i_reset),
      .i_switch(i_switch[i]),
      .o_level (o_level[i]),
      .o_rise  (o_rise[i]),
      .o_fall  (o_fall[i])
    );
  end
endmodule
